iter_alu: RTL and testbench

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/iter_alu.sv | 154 +++++++++++++++
 tb/tb_iter_alu.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/arith/shift ops (result one cycle after accept); shift-add MULU
// and restoring DIVU take WIDTH edges with in_ready low while busy, and requests made while busy are dropped.
module iter_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cmd,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_MAX = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           r_state;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_a;   // multiplicand or divisor
  logic [WIDTH-1:0] r_hi;  // partial product high half or running remainder
  logic [WIDTH-1:0] r_lo;  // multiplier/product low half or dividend/quotient

  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;

  assign in_ready = (r_state == IDLE);

  always_comb begin
    w_shamt = in2[SHW-1:0];
    w_alu   = in1 + in2;
    case (cmd)
      OP_SUB:  w_alu = in1 - in2;
      OP_AND:  w_alu = in1 & in2;
      OP_OR:   w_alu = in1 | in2;
      OP_NOR:  w_alu = ~(in1 | in2);
      OP_XOR:  w_alu = in1 ^ in2;
      OP_SLL:  w_alu = in1 << w_shamt;
      OP_SRA:  w_alu = $unsigned($signed(in1) >>> w_shamt);
      OP_SRL:  w_alu = in1 >> w_shamt;
      default: w_alu = in1 + in2;
    endcase
  end

  // One shift-add step: conditionally add, then shift {carry,hi,lo} right by one.
  always_comb begin
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    w_mul_hi = w_sum[WIDTH:1];
    w_mul_lo = {w_sum[0], r_lo[WIDTH-1:1]};
  end

  // One restoring step; when w_ge the difference is below the divisor, so WIDTH bits suffice.
  always_comb begin
    w_rem_sh = {r_hi, r_lo[WIDTH-1]};
    w_ge     = (w_rem_sh >= {1'b0, r_a});
    w_div_hi = w_ge ? (w_rem_sh[WIDTH-1:0] - r_a) : w_rem_sh[WIDTH-1:0];
    w_div_lo = {r_lo[WIDTH-2:0], w_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      out_valid   <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (cmd == OP_MULU) begin
              r_state <= MUL;
              r_cnt   <= CNT_MAX;
              r_a     <= in1;
              r_hi    <= '0;
              r_lo    <= in2;
            end else if (cmd == OP_DIVU && in2 != '0) begin
              r_state <= DIV;
              r_cnt   <= CNT_MAX;
              r_a     <= in2;
              r_hi    <= '0;
              r_lo    <= in1;
            end else if (cmd == OP_DIVU) begin
              out_valid   <= 1'b1;
              result      <= '1;
              result_hi   <= in1;
              div_by_zero <= 1'b1;
            end else begin
              out_valid   <= 1'b1;
              result      <= w_alu;
              result_hi   <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end
        MUL: begin
          r_hi <= w_mul_hi;
          r_lo <= w_mul_lo;
          if (r_cnt == '0) begin
            r_state     <= IDLE;
            out_valid   <= 1'b1;
            result      <= w_mul_lo;
            result_hi   <= w_mul_hi;
            div_by_zero <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DIV: begin
          r_hi <= w_div_hi;
          r_lo <= w_div_lo;
          if (r_cnt == '0) begin
            r_state     <= IDLE;
            out_valid   <= 1'b1;
            result      <= w_div_lo;
            result_hi   <= w_div_hi;
            div_by_zero <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_alu.sv
// Randomized self-checking bench for iter_alu against an arithmetic reference model.
module tb_iter_alu;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    cmd = 4'd0;
  logic [W-1:0]  in1 = '0;
  logic [W-1:0]  in2 = '0;
  logic          out_valid;
  logic [W-1:0]  result;
  logic [W-1:0]  result_hi;
  logic          div_by_zero;

  int errors = 0;
  int checks = 0;

  iter_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cmd(cmd), .in1(in1), .in2(in2), .out_valid(out_valid),
    .result(result), .result_hi(result_hi), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: returns {div_by_zero, result_hi, result}
  function automatic logic [2*W:0] ref_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    logic [W-1:0]   r;
    int sh;
    sh = int'(b % W);
    case (c)
      4'b0010: r = a - b;
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = ~(a | b);
      4'b0111: r = a ^ b;
      4'b1000: r = a << sh;
      4'b1001: r = $unsigned($signed(a) >>> sh);
      4'b1010: r = a >> sh;
      4'b1011: begin
        p = 64'(a) * 64'(b);
        return {1'b0, p};
      end
      4'b1100: begin
        if (b == 0) return {1'b1, a, {W{1'b1}}};
        return {1'b0, a % b, a / b};
      end
      default: r = a + b;
    endcase
    return {1'b0, {W{1'b0}}, r};
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, div_by_zero, result_hi, result} !== {2'b01, 1'b0, {2*W{1'b0}}}) begin
      errors++;
      $display("FAIL reset: got vld=%b rdy=%b dbz=%b hi=%h lo=%h, want 0 1 0 0 0",
               out_valid, in_ready, div_by_zero, result_hi, result);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sra_vector();
    @(negedge clk);
    in_valid = 1'b1; cmd = 4'b1001; in1 = 32'h8000_0000; in2 = 32'h24;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, result_hi, result} !== {1'b1, 32'h0, 32'hF800_0000}) begin
      errors++;
      $display("FAIL sra_vector: got vld=%b hi=%h lo=%h, want 1 00000000 f8000000", out_valid, result_hi, result);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1; cmd = 4'b0000; in1 = 32'd3; in2 = 32'd4;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, result} !== {2'b11, 32'h7}) begin
      errors++;
      $display("FAIL b2b_add: got vld=%b rdy=%b lo=%h, want 1 1 00000007", out_valid, in_ready, result);
    end
    cmd = 4'b0010; in1 = 32'd5; in2 = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready, result, result_hi} !== {2'b11, 32'hFFFF_FFFE, 32'h0}) begin
      errors++;
      $display("FAIL b2b_sub: got vld=%b rdy=%b lo=%h hi=%h, want 1 1 fffffffe 0", out_valid, in_ready, result, result_hi);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got vld=%b, want 0", out_valid);
    end
  endtask

  // Random single-cycle stream, one op per cycle, including undefined codes and divide-by-zero.
  task automatic test_random_single(input int n);
    logic [2*W:0] exp;
    bit pending;
    logic [3:0] c;
    logic [W-1:0] a, b;
    pending = 1'b0;
    exp = '0;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (pending) begin
        checks++;
        if ({out_valid, in_ready, div_by_zero, result_hi, result} !== {2'b11, exp}) begin
          errors++;
          $display("FAIL rand_single[%0d]: got vld=%b rdy=%b dbz=%b hi=%h lo=%h, want 1 1 %b %h %h", i,
                   out_valid, in_ready, div_by_zero, result_hi, result, exp[2*W], exp[2*W-1:W], exp[W-1:0]);
        end
      end
      if (i < n) begin
        c = 4'($urandom_range(0, 15));
        a = $urandom;
        b = $urandom;
        if (c == 4'b1011) c = 4'b0011;
        if (c == 4'b1100) b = '0;
        in_valid = 1'b1; cmd = c; in1 = a; in2 = b;
        exp = ref_op(c, a, b);
        pending = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic run_multi(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit hold, input string name);
    logic [2*W:0] exp;
    int busy_bad;
    exp = ref_op(c, a, b);
    busy_bad = 0;
    @(negedge clk);
    in_valid = 1'b1; cmd = c; in1 = a; in2 = b;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
      if (hold) begin
        cmd = 4'b0000; in1 = $urandom; in2 = $urandom;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s_busy: %0d of %0d busy cycles had rdy!=0 or vld!=0, want 0", name, busy_bad, W);
    end
    checks++;
    if ({out_valid, in_ready, div_by_zero, result_hi, result} !== {2'b11, exp}) begin
      errors++;
      $display("FAIL %s_result: got vld=%b rdy=%b dbz=%b hi=%h lo=%h, want 1 1 %b %h %h", name,
               out_valid, in_ready, div_by_zero, result_hi, result, exp[2*W], exp[2*W-1:W], exp[W-1:0]);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || {result_hi, result} !== exp[2*W-1:0]) begin
      errors++;
      $display("FAIL %s_after: got vld=%b hi=%h lo=%h, want 0 %h %h", name, out_valid, result_hi, result,
               exp[2*W-1:W], exp[W-1:0]);
    end
  endtask

  task automatic test_mulu();
    logic [W-1:0] a, b;
    run_multi(4'b1011, 32'hFFFF_FFFF, 32'h2, 1'b1, "mulu_vec");
    run_multi(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulu_max");
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      run_multi(4'b1011, a, b, i[0], "mulu_rand");
    end
  endtask

  task automatic test_divu();
    logic [W-1:0] a, b;
    run_multi(4'b1100, 32'd100, 32'd7, 1'b0, "divu_vec");
    run_multi(4'b1100, 32'hFFFF_FFFF, 32'h1, 1'b1, "divu_one");
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == 0) b = 32'd3;
      run_multi(4'b1100, a, b, i[0], "divu_rand");
    end
  endtask

  task automatic test_div_by_zero();
    @(negedge clk);
    in_valid = 1'b1; cmd = 4'b1100; in1 = 32'h1234_5678; in2 = 32'h0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready, div_by_zero, result_hi, result} !== {3'b111, 32'h1234_5678, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL div_by_zero: got vld=%b rdy=%b dbz=%b hi=%h lo=%h, want 1 1 1 12345678 ffffffff",
               out_valid, in_ready, div_by_zero, result_hi, result);
    end
  endtask

  task automatic test_reset_abort();
    int stray;
    @(negedge clk);
    in_valid = 1'b1; cmd = 4'b1011; in1 = 32'hDEAD_BEEF; in2 = 32'h1357_9BDF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, div_by_zero, result_hi, result} !== {2'b01, 1'b0, {2*W{1'b0}}}) begin
      errors++;
      $display("FAIL abort_reset: got vld=%b rdy=%b dbz=%b hi=%h lo=%h, want 0 1 0 0 0",
               out_valid, in_ready, div_by_zero, result_hi, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; cmd = 4'b0000; in1 = 32'd3; in2 = 32'd4;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, result_hi, result} !== {1'b1, 32'h0, 32'h7}) begin
      errors++;
      $display("FAIL abort_add: got vld=%b hi=%h lo=%h, want 1 0 7", out_valid, result_hi, result);
    end
    stray = 0;
    repeat (W + 8) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL abort_stray: got %0d out_valid pulses after abort, want 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_sra_vector();
    test_back_to_back();
    test_random_single(60);
    test_mulu();
    test_divu();
    test_div_by_zero();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
